// File: rtl/keypad_scanner_if.sv
// Pin-level bundle between the keypad matrix and the scanner.
// col_n is the raw asynchronous column sense; the rest are scanner outputs.
interface keypad_scanner_if;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key;
  logic       key_strobe;

  modport master (output col_n, input  row_n, key, key_strobe);
  modport slave  (input  col_n, output row_n, key, key_strobe);
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row scan, 2-flop column sync, debounced press/release,
// stable digit 0-9 on key (NOKEY otherwise) with a one-cycle strobe per accepted press.
module keypad_scanner #(
  parameter int          SCAN_DIV     = 4,
  parameter int          DEBOUNCE_CNT = 3,
  parameter logic [3:0]  NOKEY        = 4'hA
) (
  input  logic             clock,
  input  logic             reset,
  keypad_scanner_if.slave  kp
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_hit_t;

  localparam int              CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int              DW        = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0]   SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW:0]     DB_ACCEPT = (DW+1)'(DEBOUNCE_CNT);
  localparam logic [DW-1:0]   DB_ONE    = DW'(1);
  localparam logic [2:0]      ALL_HIGH  = 3'b111;

  // Exactly one low column on a mapped position yields a digit; '*', '#',
  // no column or several columns (ghosting) are all rejected.
  function automatic key_hit_t decode(input logic [1:0] r, input logic [2:0] p);
    key_hit_t   h;
    logic [1:0] c;
    logic       one;
    h   = '{vld: 1'b0, code: NOKEY};
    c   = 2'd0;
    one = 1'b1;
    case (p)
      3'b110:  c = 2'd0;
      3'b101:  c = 2'd1;
      3'b011:  c = 2'd2;
      default: one = 1'b0;
    endcase
    if (one) begin
      if (r != 2'd3) begin
        h.vld  = 1'b1;
        h.code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
      end else if (c == 2'd1) begin
        h.vld  = 1'b1;
        h.code = 4'd0;
      end
    end
    return h;
  endfunction

  logic [2:0]    cs1, cs;
  logic [CW-1:0] slot;
  logic          sample;
  state_t        state, state_nxt;
  logic [1:0]    ridx, ridx_nxt;
  logic [2:0]    lpat, lpat_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic [DW:0]   dinc;
  logic          db_done;
  logic [3:0]    key_q, key_nxt;
  logic          stb_q, stb_nxt;
  key_hit_t      hit, lhit;

  assign sample  = (slot == SLOT_LAST);
  assign dinc    = {1'b0, dcnt} + {{DW{1'b0}}, 1'b1};
  assign db_done = (dinc >= DB_ACCEPT);
  assign hit     = decode(ridx, cs);
  // Row stays frozen outside SCAN, so ridx doubles as the latched row.
  assign lhit    = decode(ridx, lpat);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cs1   <= 3'b000;
      cs    <= 3'b000;
      slot  <= '0;
      state <= SCAN;
      ridx  <= 2'd0;
      lpat  <= ALL_HIGH;
      dcnt  <= '0;
      key_q <= NOKEY;
      stb_q <= 1'b0;
    end else begin
      cs1   <= kp.col_n;
      cs    <= cs1;
      slot  <= sample ? '0 : slot + 1'b1;
      state <= state_nxt;
      ridx  <= ridx_nxt;
      lpat  <= lpat_nxt;
      dcnt  <= dcnt_nxt;
      key_q <= key_nxt;
      stb_q <= stb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ridx_nxt  = ridx;
    lpat_nxt  = lpat;
    dcnt_nxt  = dcnt;
    key_nxt   = key_q;
    stb_nxt   = 1'b0;
    if (sample) begin
      unique case (state)
        SCAN: begin
          if (hit.vld) begin
            lpat_nxt = cs;
            dcnt_nxt = DB_ONE;
            if (DEBOUNCE_CNT <= 1) begin
              state_nxt = HELD;
              key_nxt   = hit.code;
              stb_nxt   = 1'b1;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            ridx_nxt = ridx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cs == lpat) begin
            if (db_done && lhit.vld) begin
              state_nxt = HELD;
              key_nxt   = lhit.code;
              stb_nxt   = 1'b1;
            end else begin
              dcnt_nxt = dinc[DW-1:0];
            end
          end else begin
            state_nxt = SCAN;
            ridx_nxt  = ridx + 2'd1;
          end
        end
        HELD: begin
          if (cs != lpat) begin
            if (cs == ALL_HIGH && DEBOUNCE_CNT <= 1) begin
              state_nxt = SCAN;
              key_nxt   = NOKEY;
              ridx_nxt  = ridx + 2'd1;
            end else begin
              state_nxt = RELEASE;
              dcnt_nxt  = DB_ONE;
            end
          end
        end
        RELEASE: begin
          if (cs == ALL_HIGH) begin
            if (db_done) begin
              state_nxt = SCAN;
              key_nxt   = NOKEY;
              ridx_nxt  = ridx + 2'd1;
            end else begin
              dcnt_nxt = dinc[DW-1:0];
            end
          end else if (cs == lpat) begin
            // Bounce back to the same key: resume without a second strobe.
            state_nxt = HELD;
          end else begin
            dcnt_nxt = DB_ONE;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  assign kp.row_n      = ~(4'b0001 << ridx);
  assign kp.key        = key_q;
  assign kp.key_strobe = stb_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix, a vector table of
// press/release steps, and hand sequences for reset, row rotation, bounce and mid-hold reset.
module tb_keypad_scanner;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [11:0] press = '0;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .NOKEY(4'hA)) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clock = ~clock;

  // Pressed switch (r,c) pulls column c low while row r is driven low.
  always_comb begin : keypad_model
    logic [2:0] c;
    c = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 3; j++)
        if (press[r*3+j] && !kp.row_n[r]) c[j] = 1'b0;
    kp.col_n = c;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int r, input int c);
    logic [11:0] p;
    p = '0;
    p[r*3+c] = 1'b1;
    return p;
  endfunction

  task automatic run(input int n, output int nstb, output int first, output logic [3:0] stb_key);
    nstb = 0; first = -1; stb_key = 4'hF;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock); #1;
      if (kp.key_strobe) begin
        nstb++;
        if (first < 0) begin first = i; stb_key = kp.key; end
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [11:0] press;
    int          cycles;
    logic [3:0]  exp_key;
    int          exp_str;
    logic        chk_row;
    logic [3:0]  exp_row;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int ns, fst, ns2;
    logic [3:0] sk, er;

    vecs[0]  = '{"idle",        12'h000,             64, 4'hA, 0, 1'b0, 4'hF};
    vecs[1]  = '{"press6",      pk(1,2),             40, 4'h6, 1, 1'b1, 4'b1101};
    vecs[2]  = '{"rel6",        12'h000,             20, 4'hA, 0, 1'b0, 4'hF};
    vecs[3]  = '{"press2",      pk(0,1),             40, 4'h2, 1, 1'b1, 4'b1110};
    vecs[4]  = '{"add5",        pk(0,1) | pk(1,1),   40, 4'h2, 0, 1'b1, 4'b1110};
    vecs[5]  = '{"rel25",       12'h000,             20, 4'hA, 0, 1'b0, 4'hF};
    vecs[6]  = '{"press5",      pk(1,1),             40, 4'h5, 1, 1'b1, 4'b1101};
    vecs[7]  = '{"rel5",        12'h000,             20, 4'hA, 0, 1'b0, 4'hF};
    vecs[8]  = '{"star",        pk(3,0),             64, 4'hA, 0, 1'b0, 4'hF};
    vecs[9]  = '{"hash",        pk(3,2),             64, 4'hA, 0, 1'b0, 4'hF};
    vecs[10] = '{"ghost12",     pk(0,0) | pk(0,1),   64, 4'hA, 0, 1'b0, 4'hF};
    vecs[11] = '{"starhash",    pk(3,0) | pk(3,2),   64, 4'hA, 0, 1'b0, 4'hF};
    vecs[12] = '{"relall",      12'h000,             20, 4'hA, 0, 1'b0, 4'hF};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_row", kp.row_n, 4'b1110);
    chk("rst_key", kp.key, 4'hA);
    chk("rst_stb", kp.key_strobe, 1'b0);

    // Row rotation while idle: one row per 4-clock slot
    @(negedge clock); reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); #1;
      er = 4'b1111;
      er[(k/4)%4] = 1'b0;
      chk($sformatf("row_rot%0d", k), kp.row_n, er);
    end

    for (int i = 0; i < 13; i++) begin
      press = vecs[i].press;
      run(vecs[i].cycles, ns, fst, sk);
      chk({vecs[i].name, "_key"}, kp.key, vecs[i].exp_key);
      chk({vecs[i].name, "_strobes"}, ns, vecs[i].exp_str);
      if (vecs[i].chk_row) chk({vecs[i].name, "_row"}, kp.row_n, vecs[i].exp_row);
      if (vecs[i].exp_str == 1) begin
        chk({vecs[i].name, "_lat_ok"}, (fst > 0 && fst <= 31), 1);
        chk({vecs[i].name, "_stb_key"}, sk, vecs[i].exp_key);
      end
    end

    // Bouncing '0': toggles every 5 clocks, never stable for three samples
    ns2 = 0;
    press = pk(3,1);
    for (int t = 0; t < 8; t++) begin
      run(5, ns, fst, sk);
      ns2 += ns;
      press ^= pk(3,1);
    end
    chk("bounce_strobes", ns2, 0);
    chk("bounce_key", kp.key, 4'hA);
    press = pk(3,1);
    run(40, ns, fst, sk);
    chk("zero_strobes", ns, 1);
    chk("zero_key", kp.key, 4'h0);
    chk("zero_row", kp.row_n, 4'b0111);
    press = '0;
    run(20, ns, fst, sk);
    chk("zero_rel_key", kp.key, 4'hA);

    // Reset while '9' held, then re-debounce after reset release
    press = pk(2,2);
    run(40, ns, fst, sk);
    chk("nine_key", kp.key, 4'h9);
    chk("nine_strobes", ns, 1);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("midrst_key", kp.key, 4'hA);
    chk("midrst_row", kp.row_n, 4'b1110);
    chk("midrst_stb", kp.key_strobe, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    run(40, ns, fst, sk);
    chk("nine2_strobes", ns, 1);
    chk("nine2_key", kp.key, 4'h9);
    chk("nine2_lat_ok", (fst > 0 && fst <= 31), 1);
    press = '0;
    run(20, ns, fst, sk);
    chk("nine2_rel_key", kp.key, 4'hA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
